// File: rtl/shdw_dump_pkg.sv
// Shared types and sizing helpers for the shadow-chain dump transmitter.
// Lane state encoding is fixed so it can be observed on debug probes.
package shdw_dump_pkg;

   localparam int DEF_NCHAIN    = 32;
   localparam int DEF_CHAIN_LEN = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } lane_st_e;

   function automatic int cnt_width(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/shdw_dump_lane.sv
// One dump lane: freezes a chain snapshot and shifts it out LSB first.
// o_shift_nxt is the next-cycle SHIFT indication so the top can register busy.
module shdw_dump_lane
   import shdw_dump_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [CHAIN_LEN-1:0] i_snap,
   input  logic                 i_en,
   output logic                 o_out,
   output logic                 o_vld,
   output logic                 o_done,
   output logic                 o_shift_nxt
);

   localparam int              CW    = cnt_width(CHAIN_LEN);
   localparam logic [CW-1:0]   LEN_C = CW'(CHAIN_LEN);

   lane_st_e               r_st;
   logic [CHAIN_LEN-1:0]   r_shreg;
   logic [CW-1:0]          r_cnt;
   logic                   r_out;
   logic                   r_vld;
   logic                   r_done;
   logic                   w_shift_nxt;

   always_comb begin
      w_shift_nxt = 1'b0;
      if (!i_rst && i_en) begin
         unique case (r_st)
            ST_IDLE:  w_shift_nxt = 1'b1;
            ST_SHIFT: w_shift_nxt = (r_cnt != LEN_C);
            default:  w_shift_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_st    <= ST_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_vld   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_st)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_en) begin
                  // bit 0 goes out now, register holds bits 1.. for later
                  r_shreg <= i_snap >> 1;
                  r_cnt   <= CW'(1);
                  r_out   <= i_snap[0];
                  r_vld   <= 1'b1;
                  r_st    <= ST_SHIFT;
               end else begin
                  r_out <= 1'b0;
                  r_vld <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (!i_en) begin
                  r_out <= 1'b0;
                  r_vld <= 1'b0;
                  r_st  <= ST_IDLE;
               end else if (r_cnt == LEN_C) begin
                  r_out  <= 1'b0;
                  r_vld  <= 1'b0;
                  r_done <= 1'b1;
                  r_st   <= ST_DONE;
               end else begin
                  r_out   <= r_shreg[0];
                  r_shreg <= r_shreg >> 1;
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (!i_en) begin
                  r_done <= 1'b0;
                  r_st   <= ST_IDLE;
               end
            end
            default: begin
               r_out  <= 1'b0;
               r_vld  <= 1'b0;
               r_done <= 1'b0;
               r_st   <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_out       = r_out;
   assign o_vld       = r_vld;
   assign o_done      = r_done;
   assign o_shift_nxt = w_shift_nxt;

endmodule

// File: rtl/shdw_dump_tx.sv
// Shadow-core dump transmitter: NCHAIN independent serialising lanes.
// dump_busy is registered from the lanes' next-cycle shift indications.
module shdw_dump_tx
   import shdw_dump_pkg::*;
#(
   parameter int NCHAIN    = DEF_NCHAIN,
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
   input  logic                        gclk,
   input  logic                        sh_rst,
   input  logic [NCHAIN*CHAIN_LEN-1:0] snap_data,
   input  logic [NCHAIN-1:0]           dump_en,
   output logic [NCHAIN-1:0]           sh_out,
   output logic [NCHAIN-1:0]           sh_out_vld,
   output logic [NCHAIN-1:0]           sh_out_done,
   output logic                        dump_busy
);

   logic [NCHAIN-1:0] w_shift_nxt;
   logic              r_busy;

   for (genvar g = 0; g < NCHAIN; g++) begin : g_lane
      shdw_dump_lane #(
         .CHAIN_LEN (CHAIN_LEN)
      ) u_lane (
         .i_clk       (gclk),
         .i_rst       (sh_rst),
         .i_snap      (snap_data[g*CHAIN_LEN +: CHAIN_LEN]),
         .i_en        (dump_en[g]),
         .o_out       (sh_out[g]),
         .o_vld       (sh_out_vld[g]),
         .o_done      (sh_out_done[g]),
         .o_shift_nxt (w_shift_nxt[g])
      );
   end

   always_ff @(posedge gclk) begin
      if (sh_rst) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= |w_shift_nxt;
      end
   end

   assign dump_busy = r_busy;

endmodule

// File: tb/tb_shdw_dump_tx.sv
// Directed bench for shdw_dump_tx with 32 lanes of 8-bit chains.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_shdw_dump_tx;

   localparam int NC = 32;
   localparam int CL = 8;

   logic             gclk = 1'b0;
   logic             sh_rst;
   logic [NC*CL-1:0] snap_data;
   logic [NC-1:0]    dump_en;
   logic [NC-1:0]    sh_out;
   logic [NC-1:0]    sh_out_vld;
   logic [NC-1:0]    sh_out_done;
   logic             dump_busy;

   int n_chk  = 0;
   int n_fail = 0;

   shdw_dump_tx #(
      .NCHAIN    (NC),
      .CHAIN_LEN (CL)
   ) dut (
      .gclk        (gclk),
      .sh_rst      (sh_rst),
      .snap_data   (snap_data),
      .dump_en     (dump_en),
      .sh_out      (sh_out),
      .sh_out_vld  (sh_out_vld),
      .sh_out_done (sh_out_done),
      .dump_busy   (dump_busy)
   );

   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   // dump_en[ln] must already be high; checks each bit then the done cycle
   task automatic dump_chk(input int ln, input logic [7:0] exp,
                           input bit isolate);
      for (int b = 0; b < CL; b++) begin
         tick();
         chk($sformatf("vld_l%0d_b%0d", ln, b), 64'(sh_out_vld[ln]), 64'd1);
         chk($sformatf("out_l%0d_b%0d", ln, b), 64'(sh_out[ln]), 64'(exp[b]));
         chk($sformatf("busy_b%0d", b), 64'(dump_busy), 64'd1);
         if (isolate && b == 1) snap_data[ln*CL +: CL] = 8'hFF;
      end
      tick();
      chk($sformatf("end_vld_l%0d", ln), 64'(sh_out_vld[ln]), 64'd0);
      chk($sformatf("end_done_l%0d", ln), 64'(sh_out_done[ln]), 64'd1);
      chk("end_busy", 64'(dump_busy), 64'd0);
   endtask

   initial begin
      logic [NC-1:0] expv;
      sh_rst    = 1'b1;
      dump_en   = '0;
      snap_data = '0;
      tick();
      tick();
      chk("rst_out", 64'(sh_out), 64'd0);
      chk("rst_vld", 64'(sh_out_vld), 64'd0);
      chk("rst_done", 64'(sh_out_done), 64'd0);
      chk("rst_busy", 64'(dump_busy), 64'd0);

      // single dump with snapshot isolation
      sh_rst = 1'b0;
      snap_data[0 +: CL] = 8'hA5;
      tick();
      dump_en[0] = 1'b1;
      dump_chk(0, 8'hA5, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("done_hold", 64'(sh_out_done[0]), 64'd1);
      end
      dump_en[0] = 1'b0;
      tick();
      chk("done_clr", 64'(sh_out_done[0]), 64'd0);

      // abort after 3 bits then re-send from bit 0
      snap_data[0 +: CL] = 8'h3C;
      dump_en[0] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         tick();
         chk($sformatf("ab_out_b%0d", b), 64'(sh_out[0]), 64'(b >= 2));
      end
      dump_en[0] = 1'b0;
      tick();
      chk("ab_vld", 64'(sh_out_vld[0]), 64'd0);
      chk("ab_done", 64'(sh_out_done[0]), 64'd0);
      chk("ab_out", 64'(sh_out[0]), 64'd0);
      dump_en[0] = 1'b1;
      dump_chk(0, 8'h3C, 1'b0);
      dump_en[0] = 1'b0;
      tick();

      // reset during bit 4, then fresh dump with dump_en still high
      snap_data[0 +: CL] = 8'h96;
      dump_en[0] = 1'b1;
      for (int b = 0; b < 4; b++) tick();
      chk("pre_rst_out", 64'(sh_out[0]), 64'd0);
      sh_rst = 1'b1;
      tick();
      chk("mr_out", 64'(sh_out), 64'd0);
      chk("mr_vld", 64'(sh_out_vld), 64'd0);
      chk("mr_done", 64'(sh_out_done), 64'd0);
      chk("mr_busy", 64'(dump_busy), 64'd0);
      sh_rst = 1'b0;
      dump_chk(0, 8'h96, 1'b0);
      dump_en[0] = 1'b0;
      tick();

      // all lanes in parallel, lane i carries its own index
      for (int i = 0; i < NC; i++) snap_data[i*CL +: CL] = 8'(i);
      dump_en = '1;
      chk("par_busy0", 64'(dump_busy), 64'd0);
      for (int b = 0; b < CL; b++) begin
         tick();
         expv = '0;
         for (int i = 0; i < NC; i++) expv[i] = ((i >> b) & 1) != 0;
         chk($sformatf("par_out_b%0d", b), 64'(sh_out), 64'(expv));
         chk($sformatf("par_vld_b%0d", b), 64'(sh_out_vld), 64'hFFFFFFFF);
         chk($sformatf("par_busy_b%0d", b), 64'(dump_busy), 64'd1);
      end
      tick();
      chk("par_done", 64'(sh_out_done), 64'hFFFFFFFF);
      chk("par_vld_end", 64'(sh_out_vld), 64'd0);
      chk("par_busy_end", 64'(dump_busy), 64'd0);

      // hold high: no re-trigger
      for (int k = 0; k < 30; k++) begin
         tick();
         chk("hold_vld5", 64'(sh_out_vld[5]), 64'd0);
         chk("hold_done5", 64'(sh_out_done[5]), 64'd1);
      end
      chk("hold_busy", 64'(dump_busy), 64'd0);
      dump_en = '0;
      tick();
      chk("final_done", 64'(sh_out_done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shdw_dump_tx.md
Name: shdw_dump_tx

Overview:
- Shadow-core side transmitter for the dump interface consumed by shdw2mb_plb.
- When the PLB slave raises a lane's dump_en bit, the block freezes that lane's shadow-chain snapshot and serialises it one bit per gclk on sh_out.
- Each bit is qualified by sh_out_vld; sh_out_done is raised at the end of the lane's chain.
- NCHAIN independent lanes, one per shadow chain, all sharing gclk.

Parameters:
- NCHAIN, 32, number of shadow chains/lanes; must match the width of the dump_en, sh_out, sh_out_vld and sh_out_done buses.
- CHAIN_LEN, 64, bits per shadow chain snapshot; legal range 1..1024.

Ports:
- gclk  input  1  shadow-core clock; all logic is on its rising edge.
- sh_rst  input  1  synchronous, active-high reset.
- snap_data  input  NCHAIN*CHAIN_LEN  live shadow chain contents; lane i occupies bits [i*CHAIN_LEN +: CHAIN_LEN].
- dump_en  input  NCHAIN  per-lane dump request, level-sensitive.
- sh_out  output  NCHAIN  per-lane serial data bit.
- sh_out_vld  output  NCHAIN  per-lane bit-valid qualifier.
- sh_out_done  output  NCHAIN  per-lane chain-complete flag.
- dump_busy  output  1  OR of all lanes that are in SHIFT.

Behaviour:
- Clocking/reset: one clock (gclk); reset sh_rst is synchronous and active-high.
- Registered outputs: all outputs are registered (dump_busy included).
- Reset values: sh_out=0, sh_out_vld=0, sh_out_done=0, dump_busy=0; every lane FSM goes to IDLE and its counter to 0.
- Reset mid-operation: sh_rst asserted in any state forces the reset values at that edge; no partial completion and no done pulse.
- Lane FSM states: IDLE, SHIFT, DONE.
- IDLE, dump_en[i]=0: outputs 0.
- IDLE, dump_en[i]=1 at an edge:
  - shift register <= lane snapshot; cnt <= 1.
  - sh_out[i] <= snapshot bit 0; sh_out_vld[i] <= 1; next state SHIFT.
  - The first bit is visible in the cycle after the sampling edge (latency 1).
- SHIFT, dump_en[i]=1 and cnt<CHAIN_LEN:
  - sh_out[i] <= snapshot bit cnt (LSB first); cnt <= cnt+1; vld stays 1.
- SHIFT, dump_en[i]=1 and cnt==CHAIN_LEN:
  - sh_out[i] <= 0; vld <= 0; sh_out_done[i] <= 1; next state DONE.
  - Result: exactly CHAIN_LEN consecutive vld cycles, then done is high in the very next cycle.
- SHIFT, dump_en[i]=0 (abort): next state IDLE; sh_out=0, vld=0; done stays 0.
- DONE: sh_out_done[i] is held at 1 while dump_en[i]=1. When dump_en[i]=0 at an edge: done <= 0, next state IDLE.
- Re-arm: a new dump needs dump_en low for at least one edge; holding dump_en high never re-triggers.
- Snapshot isolation: snap_data changes after the capture edge do not affect the serialised bits.
- Lane independence: lanes are fully independent; any mix of simultaneous starts, aborts and completions is legal.
- CHAIN_LEN=1: one vld cycle, then done.
- Counter width is $clog2(CHAIN_LEN+1); no wrap-around is possible.

Decomposition:
- Package shdw_dump_pkg holds:
  - lane state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - function cnt_width(CHAIN_LEN);
  - default NCHAIN and CHAIN_LEN constants.
- Sub-module shdw_dump_lane contains one lane (FSM, shift register, counter).
- The top level instantiates NCHAIN lanes with a generate loop and forms dump_busy as the OR of the lanes' shifting indications.

Test Plan:
- Single dump (CHAIN_LEN=8): lane0 snapshot=8'hA5; dump_en[0] rises at edge 10.
  - Expect vld[0]=1 during cycles 11-18 with sh_out[0]=1,0,1,0,0,1,0,1.
  - Expect done[0]=1 from cycle 19 until dump_en drops, then 0 one edge later.
- Snapshot isolation: change lane0 snap_data to 8'hFF at cycle 12 -> the serial stream remains 8'hA5.
- Abort: drop dump_en[0] after 3 bits.
  - Expect vld=0 and done=0 from the next cycle.
  - Re-raise dump_en[0] -> the full 8 bits are re-sent, starting from bit 0.
- Reset mid-shift: assert sh_rst during bit 4.
  - Expect all outputs 0 next cycle and dump_busy=0.
  - With dump_en held high after reset -> a fresh dump starts the edge after sh_rst falls.
- Parallel lanes: dump_en=32'hFFFFFFFF with lane i snapshot=i.
  - Expect every lane to emit its own index LSB-first.
  - Expect all done bits high simultaneously at cycle start+9, and dump_busy high for exactly 8 cycles.
- Hold-high/no re-trigger: keep dump_en[5] high for 30 cycles after done -> no further vld pulses and done stays 1.
